isram_fetch: RTL and testbench
==============================

# isram_fetch

Parametrised instruction-fetch controller for read-only external asynchronous SRAM built from `LANES` parallel chips of `LANE_W` bits each. It sits between the CPU IF stage and the board SRAM pins and assembles one instruction word per access, with lane 0 in the least-significant bits. It adds a configurable wait-state count, a req/ready/valid handshake, flush (branch) cancellation, and an optional one-entry hit buffer that returns a repeated address without an SRAM access.

## Interface
Parameters:
- `ADDR_W`, 20: SRAM word-address width.
- `LANE_W`, 16: data width of one SRAM chip.
- `LANES`, 2: chips in parallel; `INST_W = LANE_W*LANES`, which must be a multiple of 8.
- `WAIT_CYCLES`, 2: SRAM access cycles, ≥1.
- `HIT_EN`, 1: enables the one-entry hit buffer.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `req` in 1: fetch request.
- `addr` in 32: byte address, sampled on acceptance.
- `flush` in 1: cancels any pending fetch.
- `ready` out 1: a request is accepted at the edge where `req & ready`.
- `inst_valid` out 1: one-cycle pulse, `inst` is valid.
- `inst` out INST_W: fetched word, held until the next `inst_valid`.
- `sram_addr` out ADDR_W: `addr[ADDR_W+OFS-1:OFS]`, where `OFS = log2(INST_W/8)`.
- `sram_dq_in` in INST_W: SRAM read data; lane k is `[k*LANE_W +: LANE_W]`.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n` out 1: active-low chip controls; `sram_we_n` is tied to 1.

## Operation
- FSM states: IDLE and ACCESS.
- `ready = (state==IDLE) & ~flush & ~rst`.
- In IDLE, an accepted request with `HIT_EN=1`, a valid tag, and a matching word address is a hit:
  - Stay in IDLE.
  - Next cycle: `inst` = buffered word, `inst_valid=1`.
  - The SRAM is not touched.
- In IDLE, an accepted request that is not a hit is a miss:
  - Latch `sram_addr`.
  - Go to ACCESS and load the wait counter with `WAIT_CYCLES-1`.
- In ACCESS:
  - `sram_ce_n=0`, `sram_oe_n=0`, and `sram_addr` is held stable.
  - The counter decrements each cycle.
  - At the edge where the counter is 0: capture `sram_dq_in` into `inst` and into the hit buffer, write the tag, set tag valid, set `inst_valid=1`, and return to IDLE.
- `flush` during ACCESS:
  - Return to IDLE at that edge; no capture and no `inst_valid`.
  - The tag is unchanged; SRAM controls deassert the next cycle.
- `flush` together with `req` in IDLE: the request is not accepted, because flush wins.
- `flush` in a cycle where `inst_valid=1`: no effect on that pulse; the CPU discards it.
- Back-to-back: `ready=1` in the `inst_valid` cycle, so a new request can be accepted there.
- Reset values:
  - `inst=0`, `inst_valid=0`, `sram_addr=0`.
  - `sram_ce_n=1`, `sram_oe_n=1`, `sram_we_n=1`.
  - State IDLE, tag valid 0.
- Reset mid-ACCESS: abort; the next cycle shows reset values, and no `inst_valid` is produced for the aborted fetch.
- Address wrap: upper `addr` bits above `ADDR_W+OFS` are ignored, in both the SRAM address and the tag compare.

## Timing
- A request is accepted at the end of cycle t.
- Miss:
  - `sram_ce_n`/`sram_oe_n` are low in cycles t+1 … t+WAIT_CYCLES.
  - `sram_dq_in` is sampled at the end of cycle t+WAIT_CYCLES.
  - `inst_valid` is high in cycle t+WAIT_CYCLES+1.
- Hit: `inst_valid` is high in cycle t+1.
- Throughput:
  - Misses: one fetch per WAIT_CYCLES+1 cycles.
  - Hits: one per cycle.
- All outputs are registered except `ready`.
- SRAM controls deassert in the cycle after the capture edge; the chips see no glitches between consecutive misses.

## Structure
- Package `isram_pkg`:
  - State enum `{IDLE, ACCESS}`.
  - `OFS` computation function.
  - Width-check constants (INST_W multiple of 8, WAIT_CYCLES ≥ 1), elaboration-time asserted.
- Sub-module `ifetch_hit_buf`:
  - Contents: tag register, valid bit, data register, combinational compare output.
  - With `HIT_EN=0` it is not instantiated and hit is tied to 0.
- Top: FSM, wait counter, output registers.

## Test plan
- Reset: hold `rst` for 2 cycles with `req=1` → `ready=0`, `sram_ce_n=1`, `inst=0`, `inst_valid=0`; `ready=1` in the first cycle after release.
- Miss (LANE_W=16, LANES=2, WAIT_CYCLES=2):
  - Stimulus: `req` with `addr=0x00000010`, `sram_dq_in=0x24020005`.
  - Cycles t+1..t+2: `sram_addr=0x4`, `ce_n=oe_n=0`.
  - Cycle t+3: `inst_valid=1`, `inst=0x24020005`.
- Hit: repeat `addr=0x00000010` with `sram_dq_in` changed to 0 → `inst_valid` at t+1, `inst=0x24020005`, `sram_ce_n` stays 1.
- Flush: `req` with `addr=0x20`, then `flush=1` in t+1 → no `inst_valid`, `sram_ce_n=1` at t+2; a later `req` with `0x20` is a miss (3-cycle latency).
- Back-to-back: request `0x30` accepted; `req` with `0x34` held high → second request accepted in the first `inst_valid` cycle; second `inst_valid` arrives 3 cycles later with `sram_addr=0xD`.
- Reset mid-ACCESS: `rst=1` at t+1 of a miss → no `inst_valid`, tag invalid; a refetch of the same address misses.

Source files
------------

// File: rtl/isram_fetch_pkg.sv
// Shared types and elaboration-time helpers for the instruction-fetch SRAM controller.
package isram_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Byte-offset bits dropped from the CPU byte address to form a word address.
  function automatic int ofs_of(input int inst_w);
    return $clog2(inst_w / 8);
  endfunction

  // Instruction word must be whole bytes.
  function automatic bit inst_w_ok(input int inst_w);
    return (inst_w > 0) && ((inst_w % 8) == 0);
  endfunction

  // At least one SRAM access cycle is needed.
  function automatic bit wait_ok(input int wait_cycles);
    return wait_cycles >= 1;
  endfunction

  // Wait counter width; one bit minimum so WAIT_CYCLES=1 still has a legal vector.
  function automatic int cnt_w_of(input int wait_cycles);
    return (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
  endfunction

endpackage

// File: rtl/isram_fetch_if.sv
// CPU-side fetch handshake: req/addr/flush in, ready/inst_valid/inst out.
interface isram_fetch_if #(
  parameter int INST_W = 32
);
  logic              req;
  logic [31:0]       addr;
  logic              flush;
  logic              ready;
  logic              inst_valid;
  logic [INST_W-1:0] inst;

  modport master (output req, addr, flush, input  ready, inst_valid, inst);
  modport slave  (input  req, addr, flush, output ready, inst_valid, inst);
endinterface

// File: rtl/isram_fetch_hit_buf.sv
// One-entry hit buffer: last fetched word address, valid bit and data word.
module ifetch_hit_buf #(
  parameter int ADDR_W = 20,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_tag,
  input  logic [INST_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] lk_tag,
  output logic              hit,
  output logic [INST_W-1:0] rd_data
);

  logic [ADDR_W-1:0] tag_q, tag_d;
  logic              tag_vld_q, tag_vld_d;
  logic [INST_W-1:0] data_q, data_d;

  // Load a new entry whenever a miss completes.
  always_comb begin
    tag_d     = tag_q;
    tag_vld_d = tag_vld_q;
    data_d    = data_q;
    if (wr_en) begin
      tag_d     = wr_tag;
      tag_vld_d = 1'b1;
      data_d    = wr_data;
    end
  end

  // Entry registers; reset invalidates the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q     <= '0;
      tag_vld_q <= 1'b0;
      data_q    <= '0;
    end else begin
      tag_q     <= tag_d;
      tag_vld_q <= tag_vld_d;
      data_q    <= data_d;
    end
  end

  assign hit     = tag_vld_q && (tag_q == lk_tag);
  assign rd_data = data_q;

endmodule

// File: rtl/isram_fetch.sv
// Instruction fetch from LANES parallel async SRAM chips: wait-state FSM,
// registered SRAM controls, optional single-entry hit buffer.
module isram_fetch
  import isram_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int LANE_W      = 16,
  parameter int LANES       = 2,
  parameter int WAIT_CYCLES = 2,
  parameter int HIT_EN      = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  isram_fetch_if.slave             cpu,
  output logic [ADDR_W-1:0]        sram_addr,
  input  logic [LANE_W*LANES-1:0]  sram_dq_in,
  output logic                     sram_ce_n,
  output logic                     sram_oe_n,
  output logic                     sram_we_n
);

  localparam int INST_W = LANE_W * LANES;
  localparam int OFS    = ofs_of(INST_W);
  localparam int CNT_W  = cnt_w_of(WAIT_CYCLES);

  if (!inst_w_ok(INST_W)) begin : g_bad_inst_w
    $error("isram_fetch: LANE_W*LANES must be a multiple of 8");
  end
  if (!wait_ok(WAIT_CYCLES)) begin : g_bad_wait
    $error("isram_fetch: WAIT_CYCLES must be >= 1");
  end
  if (ADDR_W + OFS > 32) begin : g_bad_addr_w
    $error("isram_fetch: ADDR_W + byte offset exceeds the 32-bit CPU address");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              ce_n_q, ce_n_d;

  logic              ready;
  logic              accept;
  logic              hit;
  logic              buf_wr;
  logic [INST_W-1:0] buf_data;
  logic [ADDR_W-1:0] req_waddr;
  logic              unused_addr;

  // Lane k sits at [k*LANE_W +: LANE_W]; lane 0 ends up in the LSBs of inst.
  logic [LANES-1:0][LANE_W-1:0] dq_lanes;
  assign dq_lanes = sram_dq_in;

  // Bits above ADDR_W+OFS wrap away; bits below OFS select a byte within the word.
  assign req_waddr   = cpu.addr[ADDR_W+OFS-1:OFS];
  assign unused_addr = ^cpu.addr;

  assign ready  = (state_q == IDLE) && !cpu.flush && !rst;
  assign accept = cpu.req && ready;

  if (HIT_EN != 0) begin : g_hit
    ifetch_hit_buf #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W)
    ) u_hit_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (buf_wr),
      .wr_tag  (sram_addr_q),
      .wr_data (dq_lanes),
      .lk_tag  (req_waddr),
      .hit     (hit),
      .rd_data (buf_data)
    );
  end else begin : g_no_hit
    assign hit      = 1'b0;
    assign buf_data = '0;
  end

  // Next state: accept/hit/miss in IDLE, count down and capture (or abort on flush) in ACCESS.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sram_addr_d  = sram_addr_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    buf_wr       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (hit) begin
            inst_d       = buf_data;
            inst_valid_d = 1'b1;
          end else begin
            sram_addr_d = req_waddr;
            cnt_d       = CNT_W'(WAIT_CYCLES - 1);
            state_d     = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cpu.flush) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          inst_d       = dq_lanes;
          inst_valid_d = 1'b1;
          buf_wr       = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Chip enable is registered from the next state so it tracks ACCESS exactly, glitch-free.
    ce_n_d = (state_d != ACCESS);
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sram_addr_q  <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      ce_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sram_addr_q  <= sram_addr_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      ce_n_q       <= ce_n_d;
    end
  end

  assign cpu.ready      = ready;
  assign cpu.inst       = inst_q;
  assign cpu.inst_valid = inst_valid_q;
  assign sram_addr      = sram_addr_q;
  assign sram_ce_n      = ce_n_q;
  assign sram_oe_n      = ce_n_q;
  assign sram_we_n      = 1'b1;

endmodule

// File: tb/tb_isram_fetch.sv
// Directed bench for isram_fetch: scoreboard of expected words, popped on inst_valid.
module tb_isram_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] sram_addr;
  logic [31:0] sram_dq_in;
  logic        ce_n, oe_n, we_n;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb[$];
  int          lat;

  isram_fetch_if #(.INST_W(32)) cpu_if ();

  isram_fetch #(
    .ADDR_W      (20),
    .LANE_W      (16),
    .LANES       (2),
    .WAIT_CYCLES (2),
    .HIT_EN      (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu        (cpu_if),
    .sram_addr  (sram_addr),
    .sram_dq_in (sram_dq_in),
    .sram_ce_n  (ce_n),
    .sram_oe_n  (oe_n),
    .sram_we_n  (we_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample on the falling edge, retire a scoreboard entry on inst_valid.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    if (cpu_if.inst_valid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_valid", cpu_if.inst_valid, 1'b0);
      else                chk("inst", cpu_if.inst, sb.pop_front());
    end
  endtask

  // Cycles until inst_valid, bounded; returns the budget on timeout.
  task automatic wait_valid(input int budget, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (cpu_if.inst_valid !== 1'b1 && n < budget);
  endtask

  initial begin
    rst = 1'b1; cpu_if.req = 1'b1; cpu_if.addr = 32'h10; cpu_if.flush = 1'b0; sram_dq_in = '0;
    @(negedge clk);
    cyc();
    chk("rst_ready", cpu_if.ready, 1'b0);
    chk("rst_ce_n", ce_n, 1'b1);
    chk("rst_oe_n", oe_n, 1'b1);
    chk("rst_we_n", we_n, 1'b1);
    chk("rst_inst", cpu_if.inst, 32'h0);
    chk("rst_valid", cpu_if.inst_valid, 1'b0);
    chk("rst_addr", sram_addr, 20'h0);
    rst = 1'b0; cpu_if.req = 1'b0; #1;
    chk("rel_ready", cpu_if.ready, 1'b1);

    // Miss at 0x10
    cpu_if.req = 1'b1; cpu_if.addr = 32'h10; sram_dq_in = 32'h24020005; #1;
    chk("miss_ready", cpu_if.ready, 1'b1);
    sb.push_back(32'h24020005);
    cyc(); cpu_if.req = 1'b0;
    chk("miss_ce_t1", ce_n, 1'b0);
    chk("miss_oe_t1", oe_n, 1'b0);
    chk("miss_addr_t1", sram_addr, 20'h4);
    chk("miss_novalid_t1", cpu_if.inst_valid, 1'b0);
    cyc();
    chk("miss_ce_t2", ce_n, 1'b0);
    chk("miss_addr_t2", sram_addr, 20'h4);
    chk("miss_novalid_t2", cpu_if.inst_valid, 1'b0);
    cyc();
    chk("miss_valid_t3", cpu_if.inst_valid, 1'b1);
    chk("miss_ce_off", ce_n, 1'b1);

    // Hit on the same address, issued in the valid cycle, with SRAM data changed
    sram_dq_in = 32'h0; cpu_if.req = 1'b1; cpu_if.addr = 32'h10; #1;
    chk("hit_ready", cpu_if.ready, 1'b1);
    sb.push_back(32'h24020005);
    cyc(); cpu_if.req = 1'b0;
    chk("hit_valid_t1", cpu_if.inst_valid, 1'b1);
    chk("hit_ce_idle", ce_n, 1'b1);
    cyc();
    chk("hit_single_pulse", cpu_if.inst_valid, 1'b0);
    chk("hit_ce_idle2", ce_n, 1'b1);
    chk("inst_hold", cpu_if.inst, 32'h24020005);

    // Flush mid-ACCESS
    cpu_if.req = 1'b1; cpu_if.addr = 32'h20; sram_dq_in = 32'hDEADBEEF;
    cyc(); cpu_if.req = 1'b0; cpu_if.flush = 1'b1; #1;
    chk("flush_ce_t1", ce_n, 1'b0);
    chk("flush_busy_ready", cpu_if.ready, 1'b0);
    cyc(); cpu_if.flush = 1'b0;
    chk("flush_ce_t2", ce_n, 1'b1);
    chk("flush_novalid_t2", cpu_if.inst_valid, 1'b0);
    chk("flush_inst_kept", cpu_if.inst, 32'h24020005);
    cyc();
    chk("flush_novalid_t3", cpu_if.inst_valid, 1'b0);

    // Flush beats req in IDLE
    cpu_if.req = 1'b1; cpu_if.addr = 32'h20; cpu_if.flush = 1'b1; #1;
    chk("flush_wins_ready", cpu_if.ready, 1'b0);
    cyc(); cpu_if.flush = 1'b0;
    chk("flush_wins_novalid", cpu_if.inst_valid, 1'b0);
    chk("flush_wins_ce", ce_n, 1'b1);

    // Refetch 0x20 must miss
    sram_dq_in = 32'h11112222; #1;
    chk("refetch_ready", cpu_if.ready, 1'b1);
    sb.push_back(32'h11112222);
    cyc(); cpu_if.req = 1'b0;
    chk("refetch_ce", ce_n, 1'b0);
    wait_valid(8, lat);
    chk("refetch_lat", lat, 2);

    // Back-to-back: 0x30 then 0x34 accepted in the first valid cycle
    cpu_if.req = 1'b1; cpu_if.addr = 32'h30; sram_dq_in = 32'hAAAA0030;
    sb.push_back(32'hAAAA0030);
    cyc(); cpu_if.addr = 32'h34; #1;
    chk("b2b_busy_ready", cpu_if.ready, 1'b0);
    chk("b2b_addr_first", sram_addr, 20'hC);
    cyc();
    cyc();
    chk("b2b_valid1", cpu_if.inst_valid, 1'b1);
    sram_dq_in = 32'hBBBB0034; #1;
    chk("b2b_ready", cpu_if.ready, 1'b1);
    sb.push_back(32'hBBBB0034);
    cyc(); cpu_if.req = 1'b0;
    chk("b2b_addr", sram_addr, 20'hD);
    chk("b2b_ce", ce_n, 1'b0);
    wait_valid(8, lat);
    chk("b2b_lat", lat, 2);

    // Upper address bits ignored in the tag compare: hit on 0x00400034
    sram_dq_in = 32'h0; cpu_if.req = 1'b1; cpu_if.addr = 32'h00400034;
    sb.push_back(32'hBBBB0034);
    cyc(); cpu_if.req = 1'b0;
    chk("wrap_hit_valid", cpu_if.inst_valid, 1'b1);
    chk("wrap_hit_ce", ce_n, 1'b1);

    // Upper address bits ignored in the SRAM address
    sram_dq_in = 32'h0000C011; cpu_if.req = 1'b1; cpu_if.addr = 32'hFFF00044;
    sb.push_back(32'h0000C011);
    cyc(); cpu_if.req = 1'b0;
    chk("wrap_addr", sram_addr, 20'hC0011);
    wait_valid(8, lat);
    chk("wrap_lat", lat, 2);

    // Reset mid-ACCESS
    cpu_if.req = 1'b1; cpu_if.addr = 32'h40; sram_dq_in = 32'h55555555;
    cyc(); cpu_if.req = 1'b0; rst = 1'b1;
    chk("rma_ce_t1", ce_n, 1'b0);
    cyc(); rst = 1'b0;
    chk("rma_ce", ce_n, 1'b1);
    chk("rma_oe", oe_n, 1'b1);
    chk("rma_inst", cpu_if.inst, 32'h0);
    chk("rma_valid", cpu_if.inst_valid, 1'b0);
    chk("rma_addr", sram_addr, 20'h0);
    cyc();
    cyc();
    chk("rma_novalid", cpu_if.inst_valid, 1'b0);

    // Previously buffered address must now miss
    sram_dq_in = 32'h77770044; cpu_if.req = 1'b1; cpu_if.addr = 32'hFFF00044;
    sb.push_back(32'h77770044);
    cyc(); cpu_if.req = 1'b0;
    chk("rma_refetch_miss", ce_n, 1'b0);
    chk("rma_refetch_novalid", cpu_if.inst_valid, 1'b0);
    wait_valid(8, lat);
    chk("rma_refetch_lat", lat, 2);
    cyc();

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
